lc_readout_sequencer: RTL and testbench

Sequences waveform readout after a local-coincidence event. It captures the per-channel local_coinc mask on the event's rising edge, then issues one readout request per participating channel to the shared readout engine, lowest index first. Each request is a valid/ready handshake followed by a done or timeout. After the last channel it applies a programmable holdoff before re-arming. It sits between the local-coincidence former and the shared waveform readout/DMA engine.

---
 rtl/lc_readout_sequencer.sv | 136 +++++++++++++
 tb/tb_lc_readout_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc_readout_sequencer.sv
// rtl/lc_readout_sequencer.sv - per-channel readout request sequencer after a local-coincidence event
module lc_readout_sequencer #(
    parameter int N_CHANNELS = 24,
    parameter int CHAN_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clr_stats,
    input  logic [N_CHANNELS-1:0] local_coinc,
    input  logic [15:0]           holdoff_len,
    input  logic [15:0]           readout_timeout,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [CHAN_W-1:0]     rd_req_chan,
    output logic [15:0]           rd_req_evt,
    input  logic                  rd_done,
    output logic                  busy,
    output logic [15:0]           evt_id,
    output logic [15:0]           drop_count,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLDOFF} state_t;

    state_t                  state, state_nx;
    logic [N_CHANNELS-1:0]   pending;
    logic                    lc_any, lc_any_prev, lc_rise;
    logic [15:0]             cnt;
    logic [15:0]             to_s;
    logic [15:0]             ho_s;
    logic [15:0]             evt_cap;
    logic [15:0]             evt_next;
    logic [CHAN_W-1:0]       lsb_idx;
    logic                    capture;
    logic                    to_hit;
    localparam logic [N_CHANNELS-1:0] ONE = {{(N_CHANNELS-1){1'b0}}, 1'b1};

    assign lc_any       = |local_coinc;
    assign lc_rise      = lc_any & ~lc_any_prev;
    assign rd_req_valid = (state == ISSUE);
    assign rd_req_chan  = lsb_idx;
    assign rd_req_evt   = evt_cap;
    assign busy         = (state != IDLE);
    // clr_stats wins over the capture increment, so the captured id follows it too
    assign evt_next     = clr_stats ? 16'd0 : evt_id + 16'd1;

    // Priority encoder: lowest set bit of pending is the next channel to request
    always_comb begin
        lsb_idx = '0;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (pending[i]) lsb_idx = CHAN_W'(i);
        end
    end

    // Next-state decode; a timeout coinciding with rd_done counts as a normal done
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        to_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (lc_rise && enable) begin
                    capture  = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (rd_req_ready) state_nx = WAIT;
            end
            WAIT: begin
                to_hit = (to_s != 16'd0) && (cnt == to_s - 16'd1) && !rd_done;
                if (rd_done || to_hit) state_nx = (pending != '0) ? ISSUE : HOLDOFF;
            end
            HOLDOFF: begin
                if (ho_s == 16'd0 || cnt == ho_s - 16'd1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sequencing state, pending mask, shared wait/holdoff counter and sampled limits
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            lc_any_prev <= 1'b0;
            cnt         <= '0;
            to_s        <= '0;
            ho_s        <= '0;
            evt_cap     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            lc_any_prev <= lc_any;
            case (state)
                IDLE: begin
                    if (capture) begin
                        pending <= local_coinc;
                        evt_cap <= evt_next;
                    end
                end
                ISSUE: begin
                    if (rd_req_ready) begin
                        pending <= pending & (pending - ONE);
                        cnt     <= '0;
                        to_s    <= readout_timeout;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (to_hit) timeout_err <= 1'b1;
                    if (state_nx == HOLDOFF) begin
                        cnt  <= '0;
                        ho_s <= holdoff_len;
                    end
                end
                HOLDOFF: cnt <= cnt + 16'd1;
                default: ;
            endcase
        end
    end

    // Event and drop statistics; clr_stats overrides any same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            evt_id     <= '0;
            drop_count <= '0;
        end else begin
            if (capture) evt_id <= evt_next;
            if (lc_rise && (state != IDLE || !enable) && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_lc_readout_sequencer.sv
// tb/tb_lc_readout_sequencer.sv - scoreboard bench for lc_readout_sequencer
module tb_lc_readout_sequencer;
    localparam int NC = 24;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clr_stats;
    logic [NC-1:0] local_coinc;
    logic [15:0]   holdoff_len;
    logic [15:0]   readout_timeout;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [CW-1:0] rd_req_chan;
    logic [15:0]   rd_req_evt;
    logic          rd_done;
    logic          busy;
    logic [15:0]   evt_id;
    logic [15:0]   drop_count;
    logic          timeout_err;

    int n_vec = 0;
    int n_err = 0;
    int done_delay = 3;
    int done_cnt = 0;
    logic [CW+15:0] exp_q[$];

    lc_readout_sequencer #(.N_CHANNELS(NC), .CHAN_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_stats(clr_stats),
        .local_coinc(local_coinc), .holdoff_len(holdoff_len),
        .readout_timeout(readout_timeout), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready), .rd_req_chan(rd_req_chan),
        .rd_req_evt(rd_req_evt), .rd_done(rd_done), .busy(busy),
        .evt_id(evt_id), .drop_count(drop_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic expect_req(input int chan, input int evt);
        exp_q.push_back({CW'(chan), 16'(evt)});
    endtask

    task automatic pulse_lc(input logic [NC-1:0] mask, input logic clr);
        local_coinc = mask;
        clr_stats   = clr;
        @(posedge clk); #1;
        local_coinc = '0;
        clr_stats   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        do begin @(negedge clk); g++; end while (busy && g < 300);
        if (busy) begin n_vec++; n_err++; $display("FAIL %s: still busy after %0d cycles", name, g); end
    endtask

    task automatic wait_accept(input string name);
        int g = 0;
        do begin @(negedge clk); g++; end while (!(rd_req_valid && rd_req_ready) && g < 300);
        if (!(rd_req_valid && rd_req_ready)) begin
            n_vec++; n_err++; $display("FAIL %s: no accept within %0d cycles", name, g);
        end
    endtask

    // Monitor: every accepted request is checked against the head of the expected queue
    initial forever begin
        @(negedge clk);
        if (!rst && rd_req_valid && rd_req_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_req: got chan %0d evt %0h expected none", rd_req_chan, rd_req_evt);
            end else begin
                logic [CW+15:0] e;
                e = exp_q.pop_front();
                if ({rd_req_chan, rd_req_evt} !== e) begin
                    n_err++;
                    $display("FAIL req: got chan %0d evt %0h expected chan %0d evt %0h",
                             rd_req_chan, rd_req_evt, e[CW+15:16], e[15:0]);
                end
            end
        end
    end

    // Readout engine model: pulse rd_done done_delay cycles after each accept
    initial begin
        rd_done = 1'b0;
        forever begin
            logic acc;
            @(negedge clk);
            acc = rd_req_valid && rd_req_ready && !rst;
            @(posedge clk); #1;
            rd_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) rd_done = 1'b1;
            end
            if (acc && done_delay > 0) done_cnt = done_delay;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int dones;
        rst = 1'b1; enable = 1'b1; clr_stats = 1'b0; local_coinc = '0;
        holdoff_len = 16'd4; readout_timeout = 16'd0; rd_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", 32'(rd_req_valid), 0);
        chk("rst_chan", 32'(rd_req_chan), 0);
        chk("rst_evt", 32'(rd_req_evt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_evt_id", 32'(evt_id), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single event, channels 0 and 2
        expect_req(0, 1); expect_req(2, 1);
        pulse_lc(24'h000005, 1'b0);
        @(negedge clk);
        chk("cap_valid", 32'(rd_req_valid), 1);
        chk("cap_evt_id", 32'(evt_id), 1);
        dones = 0; cnt = 0;
        for (int g = 0; g < 100 && dones < 2; g++) begin
            @(negedge clk);
            if (rd_done) dones++;
        end
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        chk("holdoff_cycles", 32'(cnt), 4);
        chk("single_evt_id", 32'(evt_id), 1);

        // Backpressure: ready low for 5 cycles
        @(posedge clk); #1;
        rd_req_ready = 1'b0;
        expect_req(4, 2);
        pulse_lc(24'h000010, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rd_req_valid), 1);
            chk("bp_chan", 32'(rd_req_chan), 4);
            chk("bp_evt", 32'(rd_req_evt), 2);
            @(posedge clk); #1;
        end
        rd_req_ready = 1'b1;
        wait_idle("bp_idle");

        // Timeout: no rd_done, readout_timeout=8
        done_delay = 0; readout_timeout = 16'd8;
        expect_req(0, 3); expect_req(1, 3);
        pulse_lc(24'h000003, 1'b0);
        wait_accept("to_accept");
        cnt = 0;
        for (int g = 0; g < 50; g++) begin
            @(negedge clk);
            if (timeout_err) break;
            cnt++;
        end
        chk("to_wait_cycles", 32'(cnt), 8);
        chk("to_next_valid", 32'(rd_req_valid), 1);
        wait_idle("to_idle");
        chk("to_sticky", 32'(timeout_err), 1);

        // Drops during WAIT, HOLDOFF and with enable low
        done_delay = 3; readout_timeout = 16'd0;
        expect_req(8, 4);
        pulse_lc(24'h000100, 1'b0);
        wait_accept("drop_accept");
        @(posedge clk); #1;
        pulse_lc(24'h000001, 1'b0);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!rd_done && cnt < 50);
        @(posedge clk); #1;
        pulse_lc(24'h000002, 1'b0);
        wait_idle("drop_idle");
        chk("drop_busy2", 32'(drop_count), 2);
        enable = 1'b0;
        pulse_lc(24'h000004, 1'b0);
        @(negedge clk);
        chk("drop_disabled", 32'(drop_count), 3);
        chk("drop_no_busy", 32'(busy), 0);
        enable = 1'b1;

        // evt_id wrap at 0xFFFF, highest channel
        @(posedge clk); #1;
        force dut.evt_id = 16'hFFFF;
        #1;
        release dut.evt_id;
        @(negedge clk);
        chk("preset_evt_id", 32'(evt_id), 32'hFFFF);
        expect_req(23, 0);
        pulse_lc(24'h800000, 1'b0);
        @(negedge clk);
        chk("wrap_evt_id", 32'(evt_id), 0);
        wait_idle("wrap_idle");

        // clr_stats coincident with capture
        expect_req(5, 0);
        pulse_lc(24'h000020, 1'b1);
        @(negedge clk);
        chk("clr_evt_id", 32'(evt_id), 0);
        chk("clr_drop", 32'(drop_count), 0);
        chk("clr_keeps_terr", 32'(timeout_err), 1);
        wait_idle("clr_idle");

        // Reset mid-WAIT
        done_delay = 0;
        expect_req(0, 1);
        pulse_lc(24'h000041, 1'b0);
        wait_accept("rst_accept");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(rd_req_valid), 0);
        chk("mid_rst_evt_id", 32'(evt_id), 0);
        chk("mid_rst_drop", 32'(drop_count), 0);
        chk("mid_rst_terr", 32'(timeout_err), 0);
        done_delay = 3;
        expect_req(9, 1);
        pulse_lc(24'h000200, 1'b0);
        @(negedge clk);
        chk("post_rst_evt_id", 32'(evt_id), 1);
        wait_idle("post_rst_idle");
        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
